// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one byte-level UART transmitter between two
// character requesters. A round-robin arbiter feeds a small FIFO; a
// sequencer pops it, drives the transmitter start/done handshake and can
// append CR/LF after bytes flagged as end of message.
module uart_tx_scheduler #(
    parameter int         FIFO_DEPTH = 4,
    parameter bit         TERM_EN    = 1'b1,
    parameter logic [7:0] CR_CHAR    = 8'h0D,
    parameter logic [7:0] LF_CHAR    = 8'h0A
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req0_valid,
    input  logic [7:0]                        req0_data,
    input  logic                              req0_last,
    output logic                              req0_ready,
    input  logic                              req1_valid,
    input  logic [7:0]                        req1_data,
    input  logic                              req1_last,
    output logic                              req1_ready,
    output logic [7:0]                        tx_data,
    output logic                              tx_start,
    input  logic                              tx_busy,
    input  logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              idle
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {PH_DATA = 2'd0, PH_CR = 2'd1, PH_LF = 2'd2} phase_t;

    // Each FIFO entry is {last, data}.
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          rr_q;
    logic          rr_d;

    state_t        state_q;
    phase_t        phase_q;
    logic [7:0]    cur_byte_q;
    logic          cur_last_q;
    logic [7:0]    tx_data_q;
    logic          tx_start_q;

    logic          full_s;
    logic          empty_s;
    logic          gnt0_s;
    logic          gnt1_s;
    logic          push_s;
    logic          pop_s;
    logic [8:0]    push_word_s;
    logic [8:0]    head_s;

    // Arbitration: full is taken from the registered count, so a pop in the
    // same cycle never opens a slot for a push until the following cycle.
    always_comb begin
        full_s  = (count_q == CW'(FIFO_DEPTH));
        empty_s = (count_q == {CW{1'b0}});
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        rr_d    = rr_q;
        if (!reset && !full_s) begin
            if (req0_valid && req1_valid) begin
                if (rr_q == 1'b0) begin
                    gnt0_s = 1'b1;
                    rr_d   = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                    rr_d   = 1'b0;
                end
            end else if (req0_valid) begin
                gnt0_s = 1'b1;
            end else if (req1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
        push_s      = gnt0_s | gnt1_s;
        push_word_s = gnt1_s ? {req1_last, req1_data} : {req0_last, req0_data};
        head_s      = mem_q[rd_ptr_q];
        pop_s       = (state_q == ST_IDLE) && !empty_s && !tx_busy;
    end

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
        end
    end

    // FIFO pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            rr_q     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            rr_q    <= rr_d;
        end
    end

    // Sequencer: pops a byte, issues one start pulse per byte/terminator and
    // waits for done before moving on; outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_DATA;
            cur_byte_q <= 8'h00;
            cur_last_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        cur_byte_q <= head_s[7:0];
                        cur_last_q <= head_s[8];
                        phase_q    <= PH_DATA;
                        tx_data_q  <= head_s[7:0];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        case (phase_q)
                            PH_DATA: begin
                                if (cur_last_q && TERM_EN) begin
                                    phase_q    <= PH_CR;
                                    tx_data_q  <= CR_CHAR;
                                    tx_start_q <= 1'b1;
                                    state_q    <= ST_START;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end
                            PH_CR: begin
                                phase_q    <= PH_LF;
                                tx_data_q  <= LF_CHAR;
                                tx_start_q <= 1'b1;
                                state_q    <= ST_START;
                            end
                            PH_LF: begin
                                state_q <= ST_IDLE;
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign fifo_count = count_q;
    assign idle       = (state_q == ST_IDLE) && (count_q == {CW{1'b0}});

endmodule
